// File: rtl/command_process_if.sv
// rtl/command_process_if.sv - command word and PID register bus for command_process
//
// Purpose: groups the host command input and the four registered PID
// parameter outputs into one bundle.
// Signals:
//   COMMAND      [15:0] host command, [15:14] opcode, [13:0] value
//   SETPOINT     [13:0] registered temperature setpoint
//   PROPORTIONAL [13:0] registered Kp
//   INTEGRAL     [13:0] registered Ki
//   DERIVATIVE   [13:0] registered Kd
//   CLAMPED             registered clamp flag (only with CMD_CLAMP_FLAG_EN)
// Modports: master drives COMMAND (host side), slave is the decoder.
interface command_process_if;
  logic [15:0] COMMAND;
  logic [13:0] SETPOINT;
  logic [13:0] PROPORTIONAL;
  logic [13:0] INTEGRAL;
  logic [13:0] DERIVATIVE;
`ifdef CMD_CLAMP_FLAG_EN
  logic        CLAMPED;

  modport master (output COMMAND,
                  input  SETPOINT, PROPORTIONAL, INTEGRAL, DERIVATIVE, CLAMPED);
  modport slave  (input  COMMAND,
                  output SETPOINT, PROPORTIONAL, INTEGRAL, DERIVATIVE, CLAMPED);
`else
  modport master (output COMMAND,
                  input  SETPOINT, PROPORTIONAL, INTEGRAL, DERIVATIVE);
  modport slave  (input  COMMAND,
                  output SETPOINT, PROPORTIONAL, INTEGRAL, DERIVATIVE);
`endif
endinterface

// File: rtl/command_process.sv
// rtl/command_process.sv - host command decoder for the water-heater PID registers
//
// Purpose: decodes a 16-bit command word into four 14-bit registers
// (setpoint, Kp, Ki, Kd). Setpoint writes are clamped to [SP_MIN, SP_MAX].
// All outputs are registered; a command sampled on one rising edge is
// visible right after that edge.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous reset, active-high, priority over the command
//   bus  command_process_if.slave (COMMAND in, register values out)
// Optional feature: define CMD_CLAMP_FLAG_EN to add bus.CLAMPED, high for
// the cycle following a setpoint write whose value had to be clamped.
module command_process #(
  parameter logic [13:0] SP_MIN = 14'h0DC0,
  parameter logic [13:0] SP_MAX = 14'h3200,
  parameter logic [13:0] KP_RST = 14'h0000,
  parameter logic [13:0] KI_RST = 14'h0000,
  parameter logic [13:0] KD_RST = 14'h0000
) (
  input  logic               CLK,
  input  logic               RST,
  command_process_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_SETPOINT = 2'b00,
    OP_KP       = 2'b01,
    OP_KI       = 2'b10,
    OP_KD       = 2'b11
  } opcode_t;

  opcode_t     opcode;
  logic [13:0] value;
  logic        is_nop;
  logic        too_low;
  logic        too_high;
  logic [13:0] sp_clamped;

  logic [13:0] setpoint_q, setpoint_d;
  logic [13:0] kp_q, kp_d;
  logic [13:0] ki_q, ki_d;
  logic [13:0] kd_q, kd_d;
`ifdef CMD_CLAMP_FLAG_EN
  logic        clamped_q, clamped_d;
`endif

  assign opcode   = opcode_t'(bus.COMMAND[15:14]);
  assign value    = bus.COMMAND[13:0];
  // All-zero is the idle bus value, not a setpoint write of zero.
  assign is_nop   = (bus.COMMAND == 16'h0000);
  assign too_low  = (value < SP_MIN);
  assign too_high = (value > SP_MAX);

  always_comb begin
    sp_clamped = value;
    if (too_low) begin
      sp_clamped = SP_MIN;
    end else if (too_high) begin
      sp_clamped = SP_MAX;
    end
  end

  always_comb begin
    setpoint_d = setpoint_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
`ifdef CMD_CLAMP_FLAG_EN
    clamped_d  = 1'b0;
`endif
    if (!is_nop) begin
      unique case (opcode)
        OP_SETPOINT: begin
          setpoint_d = sp_clamped;
`ifdef CMD_CLAMP_FLAG_EN
          clamped_d  = too_low | too_high;
`endif
        end
        OP_KP:   kp_d = value;
        OP_KI:   ki_d = value;
        OP_KD:   kd_d = value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      setpoint_q <= SP_MIN;
      kp_q       <= KP_RST;
      ki_q       <= KI_RST;
      kd_q       <= KD_RST;
`ifdef CMD_CLAMP_FLAG_EN
      clamped_q  <= 1'b0;
`endif
    end else begin
      setpoint_q <= setpoint_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
`ifdef CMD_CLAMP_FLAG_EN
      clamped_q  <= clamped_d;
`endif
    end
  end

  assign bus.SETPOINT     = setpoint_q;
  assign bus.PROPORTIONAL = kp_q;
  assign bus.INTEGRAL     = ki_q;
  assign bus.DERIVATIVE   = kd_q;
`ifdef CMD_CLAMP_FLAG_EN
  assign bus.CLAMPED      = clamped_q;
`endif

endmodule

// File: tb/tb_command_process.sv
// tb/tb_command_process.sv - directed vector bench for command_process
module tb_command_process;

  logic CLK;
  logic RST;
  command_process_if bus ();

  command_process dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [15:0] cmd;
    logic [13:0] sp;
    logic [13:0] kp;
    logic [13:0] ki;
    logic [13:0] kd;
    logic        cl;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] c, input logic [13:0] sp,
                     input logic [13:0] kp, input logic [13:0] ki, input logic [13:0] kd,
                     input logic cl);
    vec_t v;
    v.rst = r; v.cmd = c; v.sp = sp; v.kp = kp; v.ki = ki; v.kd = kd; v.cl = cl;
    vecs.push_back(v);
  endtask

  // Drive away from the edge, apply one rising edge, sample 1 ns later.
  task automatic apply(input logic r, input logic [15:0] c);
    @(negedge CLK);
    RST = r;
    bus.COMMAND = c;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    bus.COMMAND = 16'h0000;

    //   rst  cmd       sp        kp        ki        kd        clamped
    add(1'b1, 16'h3FFF, 14'h0DC0, 14'h0000, 14'h0000, 14'h0000, 1'b0); // reset beats command
    add(1'b0, 16'h0DC0, 14'h0DC0, 14'h0000, 14'h0000, 14'h0000, 1'b0); // min, legal
    add(1'b0, 16'h0D80, 14'h0DC0, 14'h0000, 14'h0000, 14'h0000, 1'b1); // low clamp
    add(1'b0, 16'h3FFF, 14'h3200, 14'h0000, 14'h0000, 14'h0000, 1'b1); // high clamp
    add(1'b0, 16'h3200, 14'h3200, 14'h0000, 14'h0000, 14'h0000, 1'b0); // max, legal
    add(1'b0, 16'h1280, 14'h1280, 14'h0000, 14'h0000, 14'h0000, 1'b0); // in range
    add(1'b0, 16'h6000, 14'h1280, 14'h2000, 14'h0000, 14'h0000, 1'b0); // Kp
    add(1'b0, 16'hA000, 14'h1280, 14'h2000, 14'h2000, 14'h0000, 1'b0); // Ki
    add(1'b0, 16'hE000, 14'h1280, 14'h2000, 14'h2000, 14'h2000, 1'b0); // Kd
    add(1'b0, 16'h0000, 14'h1280, 14'h2000, 14'h2000, 14'h2000, 1'b0); // NOP x3
    add(1'b0, 16'h0000, 14'h1280, 14'h2000, 14'h2000, 14'h2000, 1'b0);
    add(1'b0, 16'h0000, 14'h1280, 14'h2000, 14'h2000, 14'h2000, 1'b0);
    add(1'b0, 16'h0001, 14'h0DC0, 14'h2000, 14'h2000, 14'h2000, 1'b1); // value 1 is not NOP
    add(1'b0, 16'h0DC1, 14'h0DC1, 14'h2000, 14'h2000, 14'h2000, 1'b0); // min+1
    add(1'b0, 16'h0DBF, 14'h0DC0, 14'h2000, 14'h2000, 14'h2000, 1'b1); // min-1
    add(1'b0, 16'h31FF, 14'h31FF, 14'h2000, 14'h2000, 14'h2000, 1'b0); // max-1
    add(1'b0, 16'h3201, 14'h3200, 14'h2000, 14'h2000, 14'h2000, 1'b1); // max+1
    add(1'b0, 16'h7FFF, 14'h3200, 14'h3FFF, 14'h2000, 14'h2000, 1'b0); // gains unclamped
    add(1'b0, 16'hBFFF, 14'h3200, 14'h3FFF, 14'h3FFF, 14'h2000, 1'b0);
    add(1'b0, 16'h8000, 14'h3200, 14'h3FFF, 14'h0000, 14'h2000, 1'b0); // gain write of 0
    add(1'b1, 16'h7FFF, 14'h0DC0, 14'h0000, 14'h0000, 14'h0000, 1'b0); // mid-stream reset
    add(1'b0, 16'h4005, 14'h0DC0, 14'h0005, 14'h0000, 14'h0000, 1'b0); // held command
    add(1'b0, 16'h4005, 14'h0DC0, 14'h0005, 14'h0000, 14'h0000, 1'b0);
    add(1'b0, 16'h2000, 14'h2000, 14'h0005, 14'h0000, 14'h0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].cmd);
      chk("setpoint",     i, bus.SETPOINT,     vecs[i].sp);
      chk("proportional", i, bus.PROPORTIONAL, vecs[i].kp);
      chk("integral",     i, bus.INTEGRAL,     vecs[i].ki);
      chk("derivative",   i, bus.DERIVATIVE,   vecs[i].kd);
`ifdef CMD_CLAMP_FLAG_EN
      chk("clamped",      i, {13'd0, bus.CLAMPED}, {13'd0, vecs[i].cl});
`endif
    end

    // Latency: a new command must not reach the outputs before the edge.
    @(negedge CLK);
    RST = 1'b0;
    bus.COMMAND = 16'h5555;
    #1;
    chk("lat_kp_before", 100, bus.PROPORTIONAL, 14'h0005);
    bus.COMMAND = 16'h1000;
    #1;
    chk("lat_sp_before", 101, bus.SETPOINT, 14'h2000);
    bus.COMMAND = 16'h5555;
    @(posedge CLK);
    #1;
    chk("lat_kp_after", 102, bus.PROPORTIONAL, 14'h1555);
    chk("lat_sp_after", 103, bus.SETPOINT,     14'h2000);

`ifdef CMD_CLAMP_FLAG_EN
    // Clamp flag lasts exactly one cycle after the offending write.
    apply(1'b0, 16'h3FFF);
    chk("clamp_pulse", 104, {13'd0, bus.CLAMPED}, 14'd1);
    apply(1'b0, 16'h0000);
    chk("clamp_clear", 105, {13'd0, bus.CLAMPED}, 14'd0);
`endif

    // Reset held for several edges keeps every register at its reset value.
    apply(1'b1, 16'hFFFF);
    apply(1'b1, 16'h3FFF);
    chk("rst_hold_sp", 106, bus.SETPOINT,     14'h0DC0);
    chk("rst_hold_kp", 107, bus.PROPORTIONAL, 14'h0000);
    chk("rst_hold_kd", 108, bus.DERIVATIVE,   14'h0000);
    apply(1'b0, 16'h0000);
    chk("post_rst_nop_sp", 109, bus.SETPOINT, 14'h0DC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
